// File: rtl/lcd_480x272_timing_gen.sv
// lcd_480x272_timing_gen: 480x272 RGB panel raster timing with pixel clock-enable; LCD_TIMING_FRAME_COUNT_EN adds frame_count
module lcd_480x272_timing_gen #(
  parameter int CLK_DIV  = 3,
  parameter int H_ACTIVE = 480,
  parameter int H_FRONT  = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BACK   = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FRONT  = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BACK   = 2
) (
  input  logic       clock,
  input  logic       reset,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic       de,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       pixel_valid,
  output logic       line_start,
  output logic       frame_start
`ifdef LCD_TIMING_FRAME_COUNT_EN
  , output logic [15:0] frame_count
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = H_TOTAL > 1 ? $clog2(H_TOTAL) : 1;
  localparam int VW = V_TOTAL > 1 ? $clog2(V_TOTAL) : 1;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_LAST = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_LAST = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic [DW-1:0] div_cnt, div_nxt;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic tick, h_wrap, de_nxt, hs_nxt, vs_nxt, ls_nxt, fs_nxt;

  // next-state counters and the decode of the position they will hold
  always_comb begin
    tick = div_cnt == D_LAST;
    h_wrap = h_cnt == H_LAST;
    div_nxt = tick ? '0 : div_cnt + 1'b1;
    h_nxt = !tick ? h_cnt : h_wrap ? '0 : h_cnt + 1'b1;
    v_nxt = !(tick && h_wrap) ? v_cnt : v_cnt == V_LAST ? '0 : v_cnt + 1'b1;
    de_nxt = h_nxt < H_ACT && v_nxt < V_ACT;
    hs_nxt = !(h_nxt >= HS_FIRST && h_nxt <= HS_LAST);
    vs_nxt = !(v_nxt >= VS_FIRST && v_nxt <= VS_LAST);
    ls_nxt = tick && h_nxt == '0;
    fs_nxt = ls_nxt && v_nxt == '0;
  end

  // counters and outputs share one edge so outputs always describe the held position
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
      h_cnt <= H_LAST;
      v_cnt <= V_LAST;
      x <= '0;
      y <= '0;
      de <= 1'b0;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
      pixel_valid <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      x <= de_nxt ? 9'(h_nxt) : '0;
      y <= de_nxt ? 9'(v_nxt) : '0;
      de <= de_nxt;
      hsync_n <= hs_nxt;
      vsync_n <= vs_nxt;
      pixel_valid <= tick;
      line_start <= ls_nxt;
      frame_start <= fs_nxt;
    end
  end

`ifdef LCD_TIMING_FRAME_COUNT_EN
  // frame counter advances on the same edge that raises frame_start
  always_ff @(posedge clock) begin
    if (reset) frame_count <= '0;
    else if (fs_nxt) frame_count <= frame_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_lcd_480x272_timing_gen.sv
// tb_lcd_480x272_timing_gen: vector table, per-clock scoreboard and line/frame monitors for the raster generator
module tb_lcd_480x272_timing_gen;
  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic de, hs, vs, pv, ls, fs;
  } exp_t;
  typedef struct {
    int n;
    exp_t e;
  } vec_t;

  logic clock = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic rs_a = 1'b1, rs_b = 1'b1, rs_c = 1'b1;
  logic [8:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic de_a, hs_a, vs_a, pv_a, ls_a, fs_a;
  logic de_b, hs_b, vs_b, pv_b, ls_b, fs_b;
  logic de_c, hs_c, vs_c, pv_c, ls_c, fs_c;
`ifdef LCD_TIMING_FRAME_COUNT_EN
  logic [15:0] fc_a, fc_b, fc_c;
`endif
  int tests = 0, fails = 0;
  int na = 0, nb = 0, nc = 0;
  exp_t qa[$], qb[$], qc[$];

  initial forever #5 clock = ~clock;

  lcd_480x272_timing_gen u_dut (
    .clock(clock), .reset(rst_a), .x(x_a), .y(y_a), .de(de_a), .hsync_n(hs_a), .vsync_n(vs_a),
    .pixel_valid(pv_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef LCD_TIMING_FRAME_COUNT_EN
    , .frame_count(fc_a)
`endif
  );

  lcd_480x272_timing_gen #(.CLK_DIV(1), .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) u_small (
    .clock(clock), .reset(rst_b), .x(x_b), .y(y_b), .de(de_b), .hsync_n(hs_b), .vsync_n(vs_b),
    .pixel_valid(pv_b), .line_start(ls_b), .frame_start(fs_b)
`ifdef LCD_TIMING_FRAME_COUNT_EN
    , .frame_count(fc_b)
`endif
  );

  lcd_480x272_timing_gen #(.CLK_DIV(2), .H_ACTIVE(6), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_mid (
    .clock(clock), .reset(rst_c), .x(x_c), .y(y_c), .de(de_c), .hsync_n(hs_c), .vsync_n(vs_c),
    .pixel_valid(pv_c), .line_start(ls_c), .frame_start(fs_c)
`ifdef LCD_TIMING_FRAME_COUNT_EN
    , .frame_count(fc_c)
`endif
  );

  function automatic exp_t mk(int xv, int yv, bit d, bit h, bit v, bit p, bit l, bit f);
    exp_t e;
    e.x = 9'(xv); e.y = 9'(yv); e.de = d; e.hs = h; e.vs = v; e.pv = p; e.ls = l; e.fs = f;
    return e;
  endfunction

  // closed-form expectation n clocks after reset release
  function automatic exp_t model(int n, int cd, int ha, int hf, int hsw, int hb, int va, int vf, int vsw, int vb);
    int ht, vt, p, h, v;
    exp_t e;
    e = mk(0, 0, 0, 1, 1, 0, 0, 0);
    if (n < cd) return e;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    p = n / cd - 1;
    h = p % ht;
    v = (p / ht) % vt;
    e.de = h < ha && v < va;
    e.x = e.de ? 9'(h) : 9'd0;
    e.y = e.de ? 9'(v) : 9'd0;
    e.hs = !(h >= ha + hf && h < ha + hf + hsw);
    e.vs = !(v >= va + vf && v < va + vf + vsw);
    e.pv = n % cd == 0;
    e.ls = e.pv && h == 0;
    e.fs = e.ls && v == 0;
    return e;
  endfunction

  function automatic void chk(string name, exp_t act, exp_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got x=%0d y=%0d de=%b hs=%b vs=%b pv=%b ls=%b fs=%b, want x=%0d y=%0d de=%b hs=%b vs=%b pv=%b ls=%b fs=%b",
        name, act.x, act.y, act.de, act.hs, act.vs, act.pv, act.ls, act.fs,
        exp.x, exp.y, exp.de, exp.hs, exp.vs, exp.pv, exp.ls, exp.fs);
    end
  endfunction

  function automatic void chk_int(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endfunction

  function automatic exp_t act_a();
    return exp_t'({x_a, y_a, de_a, hs_a, vs_a, pv_a, ls_a, fs_a});
  endfunction

  // scoreboards: expectation pushed at the edge, compared once outputs settle
  initial forever begin
    @(posedge clock);
    rs_a = rst_a; rs_b = rst_b; rs_c = rst_c;
    na = rst_a ? 0 : na + 1;
    nb = rst_b ? 0 : nb + 1;
    nc = rst_c ? 0 : nc + 1;
    qa.push_back(model(na, 3, 480, 2, 41, 2, 272, 2, 10, 2));
    qb.push_back(model(nb, 1, 4, 1, 2, 1, 3, 1, 1, 1));
    qc.push_back(model(nc, 2, 6, 2, 3, 1, 5, 1, 2, 1));
  end

  initial forever begin
    @(negedge clock);
    if (qa.size() > 0) chk($sformatf("sb_a_n%0d", na), act_a(), qa.pop_front());
    if (qb.size() > 0) chk($sformatf("sb_b_n%0d", nb), exp_t'({x_b, y_b, de_b, hs_b, vs_b, pv_b, ls_b, fs_b}), qb.pop_front());
    if (qc.size() > 0) chk($sformatf("sb_c_n%0d", nc), exp_t'({x_c, y_c, de_c, hs_c, vs_c, pv_c, ls_c, fs_c}), qc.pop_front());
  end

  // full-size line monitor: visible pixels, hsync width and line period
  initial begin
    int gap, den, hst, hsc;
    bit have;
    gap = 0; den = 0; hst = 0; hsc = 0; have = 0;
    forever begin
      @(negedge clock);
      gap++;
      if (rs_a) begin
        have = 0;
        continue;
      end
      if (pv_a && ls_a) begin
        if (have) begin
          chk_int("line_de_ticks", den, 480);
          chk_int("line_hsync_ticks", hst, 41);
          chk_int("line_hsync_clocks", hsc, 123);
          chk_int("line_period_clocks", gap, 1575);
        end
        have = 1; gap = 0; den = 0; hst = 0; hsc = 0;
      end
      if (pv_a && de_a) den++;
      if (pv_a && !hs_a) hst++;
      if (!hs_a) hsc++;
    end
  end

  // reduced-size frame monitor: frame period, vsync placement and width, visible count
  initial begin
    int gap, tk, den, vst, vs0, fce;
    bit have;
    gap = 0; tk = 0; den = 0; vst = 0; vs0 = -1; fce = 0; have = 0;
    forever begin
      @(negedge clock);
      gap++;
      if (rs_c) begin
        have = 0;
        fce = 0;
`ifdef LCD_TIMING_FRAME_COUNT_EN
        chk_int("frame_count_reset", int'(fc_c), 0);
`endif
        continue;
      end
      if (pv_c) begin
        if (fs_c) begin
          fce++;
`ifdef LCD_TIMING_FRAME_COUNT_EN
          chk_int("frame_count_inc", int'(fc_c), fce);
`endif
          if (have) begin
            chk_int("frame_period_clocks", gap, 216);
            chk_int("frame_de_ticks", den, 30);
            chk_int("frame_vsync_ticks", vst, 24);
            chk_int("frame_vsync_start_tick", vs0, 72);
          end
          have = 1; gap = 0; tk = 0; den = 0; vst = 0; vs0 = -1;
        end
        if (!vs_c && vs0 < 0) vs0 = tk;
        if (de_c) den++;
        if (!vs_c) vst++;
        tk++;
      end
    end
  end

  initial begin
    vec_t tbl[12];
    int cur;
    tbl[0]  = '{0,    mk(0,   0, 0, 1, 1, 0, 0, 0)};
    tbl[1]  = '{2,    mk(0,   0, 0, 1, 1, 0, 0, 0)};
    tbl[2]  = '{3,    mk(0,   0, 1, 1, 1, 1, 1, 1)};
    tbl[3]  = '{4,    mk(0,   0, 1, 1, 1, 0, 0, 0)};
    tbl[4]  = '{6,    mk(1,   0, 1, 1, 1, 1, 0, 0)};
    tbl[5]  = '{1440, mk(479, 0, 1, 1, 1, 1, 0, 0)};
    tbl[6]  = '{1443, mk(0,   0, 0, 1, 1, 1, 0, 0)};
    tbl[7]  = '{1449, mk(0,   0, 0, 0, 1, 1, 0, 0)};
    tbl[8]  = '{1569, mk(0,   0, 0, 0, 1, 1, 0, 0)};
    tbl[9]  = '{1571, mk(0,   0, 0, 0, 1, 0, 0, 0)};
    tbl[10] = '{1572, mk(0,   0, 0, 1, 1, 1, 0, 0)};
    tbl[11] = '{1578, mk(0,   1, 1, 1, 1, 1, 1, 0)};
    repeat (3) @(negedge clock);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    cur = 0;
    for (int i = 0; i < 12; i++) begin
      while (cur < tbl[i].n) begin
        @(negedge clock);
        cur++;
      end
      chk($sformatf("vec%0d_n%0d", i, tbl[i].n), act_a(), tbl[i].e);
    end
    while (cur < 3753) begin
      @(negedge clock);
      cur++;
    end
    chk("pre_reset_x200", act_a(), mk(200, 2, 1, 1, 1, 1, 0, 0));
    rst_a = 1'b1;
    @(negedge clock);
    chk("reset_mid_line", act_a(), mk(0, 0, 0, 1, 1, 0, 0, 0));
    rst_a = 1'b0;
    repeat (2) @(negedge clock);
    chk("post_reset_clk2", act_a(), mk(0, 0, 0, 1, 1, 0, 0, 0));
    @(negedge clock);
    chk("post_reset_clk3", act_a(), mk(0, 0, 1, 1, 1, 1, 1, 1));
    rst_b = 1'b1;
    @(negedge clock);
    rst_b = 1'b0;
    rst_c = 1'b1;
    @(negedge clock);
    rst_c = 1'b0;
    repeat (600) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
